decoder_scan_sequencer: RTL and testbench

- Upstream driver for the team's 3-to-8 line decoder. Generates the 3-bit select `a` and enable `en` that step the decoder through its outputs.
- Visits only the channels enabled in a mask. Each channel is held for a programmable dwell time, with an enable-low blanking gap between channels to prevent ghosting on the decoded lines.
- Supports single-sweep and continuous-scan modes, with a start/stop/done handshake to the controlling FSM.

---
 rtl/decoder_scan_sequencer.sv | 179 +++++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving a 3-to-8 decoder: visits masked channels with dwell and blanking.
// Optional macro SCAN_REVERSE_EN adds a `dir` input for descending scans.
module decoder_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_cont,
  input  logic [7:0] mask,
`ifdef SCAN_REVERSE_EN
  input  logic       dir,
`endif
  output logic [2:0] a,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       slot_tick
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam int CNT_MAX = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [CW-1:0] CNT_DWELL = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  // With no blanking a newly selected channel goes straight to ACTIVE.
  localparam state_t        S_SLOT    = (BLANK == 0) ? S_ACTIVE : S_BLANK;
  localparam logic [CW-1:0] CNT_SLOT  = (BLANK == 0) ? CNT_DWELL : CNT_BLANK;

  // First channel of a sweep: lowest set bit, or highest when reversed.
  function automatic logic [2:0] first_bit(input logic [7:0] m, input logic rev);
    logic [2:0] r;
    r = 3'd0;
    if (rev) begin
      for (int i = 0; i < 8; i++) if (m[i]) r = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next channel after cur in scan direction; bit 3 flags that one exists.
  function automatic logic [3:0] next_bit(input logic [7:0] m, input logic [2:0] cur,
                                          input logic rev);
    logic [3:0] r;
    r = 4'd0;
    if (rev) begin
      for (int i = 0; i < 8; i++) if (m[i] && (3'(i) < cur)) r = {1'b1, 3'(i)};
    end else begin
      for (int i = 7; i >= 0; i--) if (m[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  state_t        state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic [7:0]    mask_r, mask_nx;
  logic          mode_r, mode_nx;
  logic          rev_r, rev_nx;
  logic [2:0]    a_nx;
  logic          end_scan_s;
  logic          live_rev_s;
  logic [3:0]    nxt_s;
  logic          en_nx, busy_nx, done_nx, slot_nx;

`ifdef SCAN_REVERSE_EN
  assign live_rev_s = dir;
`else
  assign live_rev_s = 1'b0;
`endif

  assign nxt_s = next_bit(mask_r, a, rev_r);

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= CNT_ZERO;
      mask_r    <= 8'd0;
      mode_r    <= 1'b0;
      rev_r     <= 1'b0;
      a         <= 3'd0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      slot_tick <= 1'b0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      mask_r    <= mask_nx;
      mode_r    <= mode_nx;
      rev_r     <= rev_nx;
      a         <= a_nx;
      en        <= en_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      slot_tick <= slot_nx;
    end
  end

  // Next-state, counter and channel selection.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    mask_nx    = mask_r;
    mode_nx    = mode_r;
    rev_nx     = rev_r;
    a_nx       = a;
    end_scan_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && !stop && (mask != 8'd0)) begin
          mask_nx  = mask;
          mode_nx  = mode_cont;
          rev_nx   = live_rev_s;
          a_nx     = first_bit(mask, live_rev_s);
          state_nx = S_SLOT;
          cnt_nx   = CNT_SLOT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_BLANK: begin
        if (stop) begin
          state_nx   = S_IDLE;
          end_scan_s = 1'b1;
        end else if (cnt_r <= CNT_ONE) begin
          state_nx = S_ACTIVE;
          cnt_nx   = CNT_DWELL;
        end else begin
          cnt_nx = cnt_r - CNT_ONE;
        end
      end
      S_ACTIVE: begin
        if (stop) begin
          state_nx   = S_IDLE;
          end_scan_s = 1'b1;
        end else if (cnt_r != CNT_ZERO) begin
          cnt_nx = cnt_r - CNT_ONE;
        end else if (nxt_s[3]) begin
          a_nx     = nxt_s[2:0];
          state_nx = S_SLOT;
          cnt_nx   = CNT_SLOT;
        end else if (mode_r && (mask != 8'd0)) begin
          // Wrap point: the live mask is re-latched only here.
          mask_nx  = mask;
          a_nx     = first_bit(mask, rev_r);
          state_nx = S_SLOT;
          cnt_nx   = CNT_SLOT;
        end else begin
          state_nx   = S_IDLE;
          end_scan_s = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = CNT_ZERO;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    en_nx   = (state_nx == S_ACTIVE);
    busy_nx = (state_nx != S_IDLE);
    done_nx = end_scan_s;
    slot_nx = (state_nx == S_ACTIVE) && (cnt_nx == CNT_ZERO);
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: instance A (DWELL=4, BLANK=1) and
// instance B (DWELL=1, BLANK=0) share inputs except start.
module tb_decoder_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b, stop, mode_cont;
  logic [7:0] mask;
`ifdef SCAN_REVERSE_EN
  logic       dir;
`endif
  logic [2:0] a_a, a_b;
  logic       en_a, en_b, busy_a, busy_b, done_a, done_b, slot_a, slot_b;

  logic       sel;
  logic [2:0] o_a;
  logic       o_en, o_busy, o_done, o_slot;

  int total = 0;
  int bad   = 0;
  int n_busy, n_en, n_ch, n_done, n_badrun, done_idx, n_both;
  logic [31:0] seq;

  decoder_scan_sequencer #(.DWELL(4), .BLANK(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .mode_cont(mode_cont),
    .mask(mask),
`ifdef SCAN_REVERSE_EN
    .dir(dir),
`endif
    .a(a_a), .en(en_a), .busy(busy_a), .done(done_a), .slot_tick(slot_a)
  );

  decoder_scan_sequencer #(.DWELL(1), .BLANK(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .mode_cont(mode_cont),
    .mask(mask),
`ifdef SCAN_REVERSE_EN
    .dir(dir),
`endif
    .a(a_b), .en(en_b), .busy(busy_b), .done(done_b), .slot_tick(slot_b)
  );

  assign o_a    = sel ? a_b    : a_a;
  assign o_en   = sel ? en_b   : en_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_slot = sel ? slot_b : slot_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the selected instance for n cycles; start_a stays high for the first hold cycles.
  task automatic observe(input int n, input int hold);
    logic pe;
    int   run;
    n_busy = 0; n_en = 0; n_ch = 0; n_done = 0; n_badrun = 0; n_both = 0;
    done_idx = -1; seq = 32'd0; pe = 1'b0; run = 0;
    for (int i = 0; i < n; i++) begin
      if (o_busy) n_busy++;
      if (o_en) begin
        n_en++;
        run++;
      end else begin
        if (pe && !sel && run != 4) n_badrun++;
        run = 0;
      end
      if (o_slot) begin
        n_ch++;
        seq = {seq[28:0], o_a};
        if (!o_en) n_badrun++;
      end
      if (o_done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
        if (o_slot) n_both++;
      end
      pe = o_en;
      start_a = (i < hold) ? 1'b1 : 1'b0;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; stop = 1'b0; mode_cont = 1'b0;
    mask = 8'd0; sel = 1'b0;
`ifdef SCAN_REVERSE_EN
    dir = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_a", {29'd0, a_a}, 32'd0);
    chk("rst_outs_a", {28'd0, en_a, busy_a, done_a, slot_a}, 32'd0);
    chk("rst_outs_b", {25'd0, a_b, en_b, busy_b, done_b, slot_b}, 32'd0);

    // Full single sweep on instance A.
    mask = 8'hFF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("ff_busy_first", {31'd0, busy_a}, 32'd1);
    chk("ff_en_first", {31'd0, en_a}, 32'd0);
    observe(50, 0);
    chk("ff_busy_cnt", n_busy, 32'd40);
    chk("ff_en_cnt", n_en, 32'd32);
    chk("ff_slots", n_ch, 32'd8);
    chk("ff_seq", seq, 32'o01234567);
    chk("ff_done", n_done, 32'd1);
    chk("ff_done_idx", done_idx, 32'd40);
    chk("ff_dwell", n_badrun, 32'd0);
    chk("ff_a_hold", {29'd0, a_a}, 32'd7);

    // Sparse mask; start re-asserted while busy with another mask/mode is ignored.
    mask = 8'b1010_0100; start_a = 1'b1;
    tick();
    mask = 8'hFF; mode_cont = 1'b1;
    observe(22, 4);
    mode_cont = 1'b0;
    chk("sp_busy_cnt", n_busy, 32'd15);
    chk("sp_seq", seq, 32'o257);
    chk("sp_slots", n_ch, 32'd3);
    chk("sp_done", n_done, 32'd1);
    chk("sp_done_idx", done_idx, 32'd15);
    chk("sp_no_overlap", n_both, 32'd0);

    // Start with empty mask is ignored.
    mask = 8'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    observe(5, 0);
    chk("m0_busy", n_busy, 32'd0);
    chk("m0_done", n_done, 32'd0);

    // Start and stop together in IDLE is ignored.
    mask = 8'hFF; start_a = 1'b1; stop = 1'b1;
    tick();
    start_a = 1'b0; stop = 1'b0;
    observe(5, 0);
    chk("ss_busy", n_busy, 32'd0);
    chk("ss_done", n_done, 32'd0);

    // Continuous scan, mask change mid-sweep, then stop during ACTIVE.
    mask = 8'h81; mode_cont = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    observe(22, 0);
    chk("ct_seq1", seq, 32'o0707);
    chk("ct_slots1", n_ch, 32'd4);
    chk("ct_nodone1", n_done, 32'd0);
    mask = 8'h02;
    observe(18, 0);
    chk("ct_seq2", seq, 32'o0711);
    chk("ct_nodone2", n_done, 32'd0);
    chk("ct_busy2", n_busy, 32'd18);
    tick();
    chk("ct_in_active", {31'd0, en_a}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0; mode_cont = 1'b0;
    chk("ct_stop_outs", {29'd0, en_a, busy_a, done_a}, 32'b001);
    tick();
    chk("ct_done_pulse", {31'd0, done_a}, 32'd0);

    // BLANK=0, DWELL=1 instance: back-to-back channels.
    mask = 8'hFF; sel = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b0_first", {28'd0, a_b, en_b}, 32'b0001);
    observe(12, 0);
    chk("b0_en_cnt", n_en, 32'd8);
    chk("b0_seq", seq, 32'o01234567);
    chk("b0_done", n_done, 32'd1);
    chk("b0_done_idx", done_idx, 32'd8);
    sel = 1'b0;

    // Reset during ACTIVE: everything clears, no done.
    mask = 8'hFF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("rm_active", {31'd0, en_a}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rm_outs", {25'd0, a_a, en_a, busy_a, done_a, slot_a}, 32'd0);
    observe(6, 0);
    chk("rm_busy", n_busy, 32'd0);
    chk("rm_done", n_done, 32'd0);

`ifdef SCAN_REVERSE_EN
    // Descending sweep.
    dir = 1'b1; mask = 8'h16; start_a = 1'b1;
    tick();
    start_a = 1'b0; dir = 1'b0;
    observe(20, 0);
    chk("rv_seq", seq, 32'o421);
    chk("rv_slots", n_ch, 32'd3);
    chk("rv_busy", n_busy, 32'd15);
    chk("rv_done", n_done, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
